// File: rtl/ii_stream_gen.sv
// ii_stream_gen: builds the integral image (ii) and the squared integral image
// (sii) from a raster pixel stream. It emits one ii word and one sii word per
// accepted pixel, each on its own valid/ready stream with end-of-row and
// end-of-frame markers.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pix_valid/ready   input pixel handshake; pix_data is an unsigned pixel
//   ii_valid/ready    ii output stream; ii_data, ii_eot[0]=last column, [1]=last pixel
//   sii_valid/ready   sii output stream; sii_data, sii_eot (same encoding)
//   sat_flag          sticky saturation status (only with II_SATURATE_EN)
//
// Optional build macro: II_SATURATE_EN. When it is defined, the adders clamp
// at their maximum value instead of wrapping, and the sat_flag port is added.
module ii_stream_gen #(
  parameter int unsigned W_PIX      = 8,
  parameter int unsigned IMG_WIDTH  = 25,
  parameter int unsigned IMG_HEIGHT = 25,
  parameter int unsigned W_II       = 18,
  parameter int unsigned W_SII      = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [W_PIX-1:0]   pix_data,
  output logic               ii_valid,
  input  logic               ii_ready,
  output logic [W_II-1:0]    ii_data,
  output logic [1:0]         ii_eot,
  output logic               sii_valid,
  input  logic               sii_ready,
  output logic [W_SII-1:0]   sii_data,
  output logic [1:0]         sii_eot
`ifdef II_SATURATE_EN
  ,
  output logic               sat_flag
`endif
);

  localparam int unsigned W_X  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned W_Y  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned W_SQ = 2 * W_PIX;

  // Raster position and per-row state
  logic [W_X-1:0]   x_q, x_d;
  logic [W_Y-1:0]   y_q, y_d;
  logic             first_row_q, first_row_d;
  logic [W_II-1:0]  rs_ii_q, rs_ii_d;
  logic [W_SII-1:0] rs_sq_q, rs_sq_d;

  // Line buffers: previous row's ii/sii per column
  logic [W_II-1:0]  lb_ii_q [IMG_WIDTH];
  logic [W_SII-1:0] lb_sq_q [IMG_WIDTH];

  // Output slots
  logic             ii_valid_q, ii_valid_d;
  logic [W_II-1:0]  ii_data_q, ii_data_d;
  logic [1:0]       ii_eot_q, ii_eot_d;
  logic             sii_valid_q, sii_valid_d;
  logic [W_SII-1:0] sii_data_q, sii_data_d;
  logic [1:0]       sii_eot_q, sii_eot_d;

  logic             accept;
  logic             last_col, last_row;
  logic [W_SQ-1:0]  pix_sq;
  logic [W_II-1:0]  lb_ii_rd, rs_ii_new, ii_new;
  logic [W_SII-1:0] lb_sq_rd, rs_sq_new, sii_new;

`ifdef II_SATURATE_EN
  logic             sat_q, sat_d;
  logic             sat_hit;
`endif

  // Fork handshake: a pixel is taken only when both slots can accept a word
  assign pix_ready = rst && (!ii_valid_q || ii_ready) && (!sii_valid_q || sii_ready);
  assign accept    = pix_valid && pix_ready;

  assign last_col  = (x_q == W_X'(IMG_WIDTH - 1));
  assign last_row  = (y_q == W_Y'(IMG_HEIGHT - 1));

  assign pix_sq    = W_SQ'(pix_data) * W_SQ'(pix_data);

  // The first row of a frame has nothing above it
  assign lb_ii_rd  = first_row_q ? '0 : lb_ii_q[x_q];
  assign lb_sq_rd  = first_row_q ? '0 : lb_sq_q[x_q];

`ifdef II_SATURATE_EN
  // Saturating adders: a carry out clamps the result to all ones
  logic [W_II:0]  rs_ii_sum, ii_sum;
  logic [W_SII:0] rs_sq_sum, sii_sum;

  always_comb begin
    rs_ii_sum = {1'b0, rs_ii_q} + (W_II+1)'(pix_data);
    rs_ii_new = rs_ii_sum[W_II] ? '1 : rs_ii_sum[W_II-1:0];
    rs_sq_sum = {1'b0, rs_sq_q} + (W_SII+1)'(pix_sq);
    rs_sq_new = rs_sq_sum[W_SII] ? '1 : rs_sq_sum[W_SII-1:0];
    ii_sum    = {1'b0, rs_ii_new} + {1'b0, lb_ii_rd};
    ii_new    = ii_sum[W_II] ? '1 : ii_sum[W_II-1:0];
    sii_sum   = {1'b0, rs_sq_new} + {1'b0, lb_sq_rd};
    sii_new   = sii_sum[W_SII] ? '1 : sii_sum[W_SII-1:0];
    sat_hit   = rs_ii_sum[W_II] | ii_sum[W_II] | rs_sq_sum[W_SII] | sii_sum[W_SII];
  end
`else
  // Modulo adders
  always_comb begin
    rs_ii_new = rs_ii_q + W_II'(pix_data);
    rs_sq_new = rs_sq_q + W_SII'(pix_sq);
    ii_new    = rs_ii_new + lb_ii_rd;
    sii_new   = rs_sq_new + lb_sq_rd;
  end
`endif

  // Next-state: slot drain/reload, raster counters, row sums
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    first_row_d = first_row_q;
    rs_ii_d     = rs_ii_q;
    rs_sq_d     = rs_sq_q;
    ii_valid_d  = ii_valid_q;
    ii_data_d   = ii_data_q;
    ii_eot_d    = ii_eot_q;
    sii_valid_d = sii_valid_q;
    sii_data_d  = sii_data_q;
    sii_eot_d   = sii_eot_q;
`ifdef II_SATURATE_EN
    sat_d       = sat_q;
`endif

    if (ii_valid_q && ii_ready)   ii_valid_d  = 1'b0;
    if (sii_valid_q && sii_ready) sii_valid_d = 1'b0;

    if (accept) begin
      ii_valid_d  = 1'b1;
      ii_data_d   = ii_new;
      ii_eot_d    = {last_col && last_row, last_col};
      sii_valid_d = 1'b1;
      sii_data_d  = sii_new;
      sii_eot_d   = {last_col && last_row, last_col};
      rs_ii_d     = rs_ii_new;
      rs_sq_d     = rs_sq_new;
`ifdef II_SATURATE_EN
      // First pixel of a frame restarts the sticky flag
      sat_d = ((x_q == '0 && y_q == '0) ? 1'b0 : sat_q) | sat_hit;
`endif
      if (last_col) begin
        // Row sums restart at column 0 of every row
        x_d     = '0;
        rs_ii_d = '0;
        rs_sq_d = '0;
        if (last_row) begin
          y_d         = '0;
          first_row_d = 1'b1;
        end else begin
          y_d         = y_q + W_Y'(1);
          first_row_d = 1'b0;
        end
      end else begin
        x_d = x_q + W_X'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      y_q         <= '0;
      first_row_q <= 1'b1;
      rs_ii_q     <= '0;
      rs_sq_q     <= '0;
      ii_valid_q  <= 1'b0;
      ii_data_q   <= '0;
      ii_eot_q    <= '0;
      sii_valid_q <= 1'b0;
      sii_data_q  <= '0;
      sii_eot_q   <= '0;
`ifdef II_SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      first_row_q <= first_row_d;
      rs_ii_q     <= rs_ii_d;
      rs_sq_q     <= rs_sq_d;
      ii_valid_q  <= ii_valid_d;
      ii_data_q   <= ii_data_d;
      ii_eot_q    <= ii_eot_d;
      sii_valid_q <= sii_valid_d;
      sii_data_q  <= sii_data_d;
      sii_eot_q   <= sii_eot_d;
`ifdef II_SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  // Line buffer write; contents need no reset since first_row masks the read
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_ii_q[x_q] <= ii_new;
      lb_sq_q[x_q] <= sii_new;
    end
  end

  assign ii_valid  = ii_valid_q;
  assign ii_data   = ii_data_q;
  assign ii_eot    = ii_eot_q;
  assign sii_valid = sii_valid_q;
  assign sii_data  = sii_data_q;
  assign sii_eot   = sii_eot_q;
`ifdef II_SATURATE_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_ii_stream_gen.sv
// Testbench for ii_stream_gen: directed frames with expected ii/sii words
// computed by an independent direct-summation reference.
module tb_ii_stream_gen;

  localparam int unsigned W_PIX    = 8;
  localparam int unsigned IW       = 25;
  localparam int unsigned IH       = 25;
  localparam int unsigned NPIX     = IW * IH;
  localparam int unsigned W_SII_TB = 26;
`ifdef II_SATURATE_EN
  localparam int unsigned W_II_TB  = 10;
  localparam bit          SAT      = 1'b1;
`else
  localparam int unsigned W_II_TB  = 18;
  localparam bit          SAT      = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                pix_valid = 1'b0;
  logic                pix_ready;
  logic [W_PIX-1:0]    pix_data = '0;
  logic                ii_valid;
  logic                ii_ready = 1'b1;
  logic [W_II_TB-1:0]  ii_data;
  logic [1:0]          ii_eot;
  logic                sii_valid;
  logic                sii_ready = 1'b1;
  logic [W_SII_TB-1:0] sii_data;
  logic [1:0]          sii_eot;
`ifdef II_SATURATE_EN
  logic                sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  logic [W_PIX-1:0]    pix_stim[$];
  logic [W_II_TB-1:0]  got_ii[$];
  logic [1:0]          got_ii_eot[$];
  logic [W_SII_TB-1:0] got_sii[$];
  logic [1:0]          got_sii_eot[$];

  always #5 clk = ~clk;

  ii_stream_gen #(
    .W_PIX(W_PIX), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W_II(W_II_TB), .W_SII(W_SII_TB)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .ii_valid(ii_valid), .ii_ready(ii_ready), .ii_data(ii_data), .ii_eot(ii_eot),
    .sii_valid(sii_valid), .sii_ready(sii_ready), .sii_data(sii_data), .sii_eot(sii_eot)
`ifdef II_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  // Output monitors: a word seen valid&&ready here transfers at the next edge
  always @(negedge clk) begin
    if (ii_valid && ii_ready) begin
      got_ii.push_back(ii_data);
      got_ii_eot.push_back(ii_eot);
    end
    if (sii_valid && sii_ready) begin
      got_sii.push_back(sii_data);
      got_sii_eot.push_back(sii_eot);
    end
    if (pix_valid && !pix_ready) stall_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

  function automatic longint fit(input longint v, input int unsigned w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (SAT) return (v > mx) ? mx : v;
    return v & mx;
  endfunction

  // Direct rectangle sum over pixels (0..x, 0..y) of the frame at base
  function automatic longint rect_sum(input int base, input int x, input int y, input bit sq);
    longint s = 0;
    longint p;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++) begin
        p = longint'(pix_stim[base + j * IW + i]);
        s += sq ? p * p : p;
      end
    return s;
  endfunction

  task automatic flush_queues();
    got_ii.delete(); got_ii_eot.delete();
    got_sii.delete(); got_sii_eot.delete();
  endtask

  task automatic send_pixels(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      pix_data  = pix_stim[k];
      w = 0;
      @(negedge clk);
      while (!pix_ready && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (!pix_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout: pixel %0d not accepted, pix_ready=%b required 1", k, pix_ready);
        pix_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int n);
    int w = 0;
    while ((got_ii.size() < n || got_sii.size() < n) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_ii.size() != n || got_sii.size() != n) begin
      errors++;
      $display("FAIL %s word_count: ii=%0d sii=%0d required %0d each", name, got_ii.size(), got_sii.size(), n);
    end
  endtask

  task automatic compare_frames(input string name, input int n);
    longint eii, esii;
    logic [1:0] eeot;
    int f, r, x, y;
    for (int k = 0; k < n; k++) begin
      f = k / NPIX; r = k % NPIX; x = r % IW; y = r / IW;
      eii  = fit(rect_sum(f * NPIX, x, y, 1'b0), W_II_TB);
      esii = fit(rect_sum(f * NPIX, x, y, 1'b1), W_SII_TB);
      eeot = {(x == IW - 1) && (y == IH - 1), x == IW - 1};
      checks++;
      if (got_ii[k] !== W_II_TB'(eii) || got_ii_eot[k] !== eeot) begin
        errors++;
        $display("FAIL %s ii[%0d]: got %0d eot %b, required %0d eot %b", name, k, got_ii[k], got_ii_eot[k], eii, eeot);
      end
      checks++;
      if (got_sii[k] !== W_SII_TB'(esii) || got_sii_eot[k] !== eeot) begin
        errors++;
        $display("FAIL %s sii[%0d]: got %0d eot %b, required %0d eot %b", name, k, got_sii[k], got_sii_eot[k], esii, eeot);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (ii_valid !== 1'b0 || sii_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: ii_valid=%b sii_valid=%b required 0", ii_valid, sii_valid);
    end
    checks++;
    if (ii_data !== '0 || sii_data !== '0) begin
      errors++;
      $display("FAIL reset_data: ii=%0d sii=%0d required 0", ii_data, sii_data);
    end
    checks++;
    if (ii_eot !== 2'b00 || sii_eot !== 2'b00) begin
      errors++;
      $display("FAIL reset_eot: ii_eot=%b sii_eot=%b required 00", ii_eot, sii_eot);
    end
`ifdef II_SATURATE_EN
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat_flag: got %b required 0", sat_flag);
    end
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    flush_queues();
  endtask

  task automatic test_all_ones();
    int n0, n1;
    pix_stim.delete();
    for (int k = 0; k < NPIX; k++) pix_stim.push_back(8'd1);
    ii_ready = 1'b1; sii_ready = 1'b1;
    stall_cnt = 0;
    flush_queues();
    send_pixels(NPIX);
    checks++;
    if (stall_cnt != 0) begin
      errors++;
      $display("FAIL ones_throughput: stall cycles=%0d required 0", stall_cnt);
    end
    wait_drain("ones", NPIX);
    compare_frames("ones", NPIX);
    checks++;
    if (got_ii[0] !== W_II_TB'(1) || got_ii_eot[0] !== 2'b00) begin
      errors++;
      $display("FAIL ones_first: got %0d eot %b required 1 eot 00", got_ii[0], got_ii_eot[0]);
    end
    checks++;
    if (got_ii[24] !== W_II_TB'(25) || got_ii_eot[24] !== 2'b01) begin
      errors++;
      $display("FAIL ones_row_end: got %0d eot %b required 25 eot 01", got_ii[24], got_ii_eot[24]);
    end
    checks++;
    if (got_ii[NPIX-1] !== W_II_TB'(625) || got_sii[NPIX-1] !== W_SII_TB'(625) || got_ii_eot[NPIX-1] !== 2'b11) begin
      errors++;
      $display("FAIL ones_last: ii=%0d sii=%0d eot %b required 625/625 eot 11", got_ii[NPIX-1], got_sii[NPIX-1], got_ii_eot[NPIX-1]);
    end
    n0 = 0; n1 = 0;
    for (int k = 0; k < got_ii_eot.size(); k++) begin
      if (got_ii_eot[k][0]) n0++;
      if (got_ii_eot[k][1]) n1++;
    end
    checks++;
    if (n0 != 25 || n1 != 1) begin
      errors++;
      $display("FAIL ones_eot_count: eot0=%0d eot1=%0d required 25 and 1", n0, n1);
    end
  endtask

  task automatic test_all_255();
    pix_stim.delete();
    for (int k = 0; k < NPIX; k++) pix_stim.push_back(8'd255);
    flush_queues();
    send_pixels(NPIX);
    wait_drain("all255", NPIX);
    compare_frames("all255", NPIX);
    checks++;
    if (got_ii[0] !== W_II_TB'(255) || got_sii[0] !== W_SII_TB'(65025)) begin
      errors++;
      $display("FAIL all255_first: ii=%0d sii=%0d required 255/65025", got_ii[0], got_sii[0]);
    end
    checks++;
    if (got_ii[NPIX-1] !== W_II_TB'(SAT ? 1023 : 159375) || got_sii[NPIX-1] !== W_SII_TB'(40640625)) begin
      errors++;
      $display("FAIL all255_last: ii=%0d sii=%0d required %0d/40640625", got_ii[NPIX-1], got_sii[NPIX-1], SAT ? 1023 : 159375);
    end
`ifdef II_SATURATE_EN
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL all255_sat_flag: got %b required 1", sat_flag);
    end
`endif
  endtask

  task automatic test_backpressure();
    pix_stim.delete();
    for (int k = 0; k < NPIX; k++) pix_stim.push_back(8'((k * 7 + 3) % 256));
    flush_queues();
    fork
      send_pixels(NPIX);
      begin
        repeat (100) @(posedge clk);
        #1 ii_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pix_ready cycle %0d: got %b required 0", c, pix_ready);
          end
          if (c >= 1) begin
            checks++;
            if (sii_valid !== 1'b0) begin
              errors++;
              $display("FAIL bp_sii_empty cycle %0d: sii_valid=%b required 0", c, sii_valid);
            end
          end
        end
        @(posedge clk);
        #1 ii_ready = 1'b1;
      end
    join
    wait_drain("backpressure", NPIX);
    compare_frames("backpressure", NPIX);
  endtask

  task automatic test_back_to_back();
    pix_stim.delete();
    for (int k = 0; k < NPIX; k++) pix_stim.push_back(8'((k * 13) % 256));
    for (int k = 0; k < NPIX; k++) pix_stim.push_back(8'd1);
    flush_queues();
    send_pixels(2 * NPIX);
    wait_drain("b2b", 2 * NPIX);
    compare_frames("b2b", 2 * NPIX);
    checks++;
    if (got_ii[NPIX] !== W_II_TB'(1) || got_ii[2*NPIX-1] !== W_II_TB'(625) || got_sii[2*NPIX-1] !== W_SII_TB'(625)) begin
      errors++;
      $display("FAIL b2b_second_frame: first=%0d last ii=%0d sii=%0d required 1/625/625",
               got_ii[NPIX], got_ii[2*NPIX-1], got_sii[2*NPIX-1]);
    end
`ifdef II_SATURATE_EN
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sat_flag_cleared: got %b required 0", sat_flag);
    end
`endif
  endtask

  task automatic test_reset_mid();
    pix_stim.delete();
    for (int k = 0; k < 40; k++) pix_stim.push_back(8'(k + 5));
    flush_queues();
    send_pixels(40);
    checks++;
    if (ii_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_valid: ii_valid=%b required 1", ii_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ii_valid !== 1'b0 || sii_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid_drop: ii_valid=%b sii_valid=%b required 0", ii_valid, sii_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    flush_queues();
    pix_stim.delete();
    for (int k = 0; k < NPIX; k++) pix_stim.push_back(8'd1);
    send_pixels(NPIX);
    wait_drain("midrst", NPIX);
    compare_frames("midrst", NPIX);
    checks++;
    if (got_ii[0] !== W_II_TB'(1) || got_ii_eot[0] !== 2'b00) begin
      errors++;
      $display("FAIL midrst_first_word: got %0d eot %b required 1 eot 00", got_ii[0], got_ii_eot[0]);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_255();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ii_stream_gen.md
Name: ii_stream_gen

Overview:
- Builds the integral image (ii) and squared integral image (sii) from a raster pixel stream.
- Emits ii and sii as two independent valid/ready streams, each with eot markers. These are the transmitter side of the ii/sii inputs consumed by the stddev/window_sum path.
- Sits between the frame/pixel source and the stddev block.
- One output word per input pixel, in raster order.

Parameters:
- W_PIX, 8, input pixel width.
- IMG_WIDTH, 25, pixels per row.
- IMG_HEIGHT, 25, rows per frame.
- W_II, 18, ii output width (default holds 25*25*255).
- W_SII, 26, sii output width (default holds 25*25*255^2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  input pixel accepted when high with pix_valid.
- pix_data  in  W_PIX  unsigned pixel.
- ii_valid  out  1  ii word valid.
- ii_ready  in  1  downstream ready for ii.
- ii_data  out  W_II  ii value.
- ii_eot  out  2  [0] last column of row, [1] last pixel of frame.
- sii_valid  out  1  sii word valid.
- sii_ready  in  1  downstream ready for sii.
- sii_data  out  W_SII  sii value.
- sii_eot  out  2  same encoding as ii_eot.

Behaviour:
- Reset (rst low, async):
  - ii_valid=0, sii_valid=0, ii_data=0, sii_data=0, eot=0.
  - Column/row counters = 0; row sums = 0; first_row flag = 1.
  - Row buffer contents are don't-care.
- Math, for pixel p at (x,y):
  - rs_ii += p, rs_sq += p*p; both row sums clear at x=0.
  - ii(x,y) = rs_ii + (first_row ? 0 : lb_ii[x]); sii is computed the same way with rs_sq and lb_sq.
  - lb_ii[x] and lb_sq[x] are then overwritten with the new values.
  - p*p is computed at 2*W_PIX bits. All sums are unsigned, modulo 2^W_II / 2^W_SII (wrap) unless the optional feature is enabled.
- Line buffer: two IMG_WIDTH-deep arrays (W_II and W_SII wide), read and written at index x in the accept cycle. Any implementation (regs or RAM) is acceptable if 1-cycle latency is met.
- Output slots: one register per stream with its own valid flag.
  - Transfer on a stream when valid&&ready.
  - Valid stays high and data/eot stay stable until that transfer.
- Fork rule:
  - pix_ready = (!ii_valid || ii_ready) && (!sii_valid || sii_ready).
  - On accept, both slots load in the same cycle and both valids set the next cycle. Latency is 1 cycle.
  - A stream that has already transferred waits empty for the other; no word is duplicated or dropped.
  - Full throughput (1 pixel/cycle) when both readies are held high.
- eot generation:
  - eot[0]=1 when x==IMG_WIDTH-1.
  - eot[1]=1 when x==IMG_WIDTH-1 and y==IMG_HEIGHT-1; eot[0] is also 1 on that word.
  - Identical on ii and sii for the same pixel.
- Counters:
  - x wraps at IMG_WIDTH-1, y increments on x wrap.
  - At frame end: x=0, y=0, first_row=1, row sums cleared, so the next frame starts independently.
  - first_row clears at the first row wrap.
- Simultaneous events: a slot draining and reloading in the same cycle is legal (back-to-back).
- Reset mid-frame: all in-flight output is discarded. The next accepted pixel is treated as (0,0) of a new frame.
- No pixel is accepted while rst is low.

Optional Feature:
- Macro: II_SATURATE_EN.
- Defined:
  - ii and sii adders saturate at 2^W_II-1 / 2^W_SII-1; the saturated value is also written to the line buffer.
  - Adds a sticky status output sat_flag (1 bit, reset 0). It sets on any saturation and clears at the first pixel of the next frame.
- Undefined:
  - Modulo wrap arithmetic; no sat_flag port.

Test Plan:
- All-ones 25x25 frame, readies high -> ii(x,y)=(x+1)(y+1), sii identical, last word 625. eot[0] on every x=24; eot[1] only on word 625. Throughput 1/cycle.
- All-255 frame -> final ii=159375, final sii=40640625, no wrap. Pixel (0,0) gives ii=255, sii=65025.
- Backpressure: ii_ready low for 5 cycles, sii_ready high -> pix_ready low until ii drains. sii holds one word without duplication, and word sequences on both streams match the reference model.
- Two back-to-back frames (ramp, then all-ones) -> second frame values equal the standalone all-ones results; no carry-over from the line buffer.
- Reset asserted after 40 pixels -> valids drop immediately. Next frame, all ones -> first word ii=1 with eot=0.
- II_SATURATE_EN with W_II=10, all-255 frame -> ii clamps at 1023 and sat_flag=1. sat_flag clears when the next frame's first pixel is accepted.
